// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO: ceiling log2 and the
// derived pointer and occupancy widths.
package fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Occupancy runs 0..WORDS inclusive, so it needs one more code than a pointer.
  function automatic int count_width(input int words);
    return clog2(words + 1);
  endfunction

  function automatic int ptr_width(input int words);
    return (words > 1) ? clog2(words) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync_param_mem.sv
// WORDS x N register array with one synchronous write port and one
// asynchronous read port; contents are never cleared.
module fifo_sync_param_mem
  import fifo_pkg::*;
#(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [ptr_width(WORDS)-1:0] wr_addr,
  input  logic [N-1:0]               wr_data,
  input  logic [ptr_width(WORDS)-1:0] rd_addr,
  output logic [N-1:0]               rd_data
);

  logic [N-1:0] mem [WORDS];

  // NOTE: storage has no reset; occupancy state alone decides which words are valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Synchronous first-word-fall-through FIFO with occupancy flags, MSB-word
// detection and sticky overflow/underflow errors.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int N         = 8,
  parameter int WORDS     = 4,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [N-1:0]                 DIN,
  input  logic                         SI,
  input  logic                         SO,
  input  logic                         SLEEPER,
  output logic [N-1:0]                 DOUT,
  output logic                         IREADY,
  output logic                         OREADY,
  output logic [WORDS-1:0]             FOUT,
  output logic [count_width(WORDS)-1:0] COUNT,
  output logic                         AFULL,
  output logic                         AEMPTY,
  output logic                         DETECT1,
  output logic                         OVF,
  output logic                         UNF
);

  localparam int CW = count_width(WORDS);
  localparam int PW = ptr_width(WORDS);
  localparam logic [PW-1:0] LAST_PTR = PW'(WORDS - 1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] msb_count;
  logic          ovf;
  logic          unf;
  logic          push;
  logic          pop;
  logic          push_msb;
  logic          pop_msb;
  logic [N-1:0]  rd_data;

  // Explicit wrap so a non power-of-two depth never walks past the last word.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  assign push     = SI & IREADY;
  assign pop      = SO & OREADY;
  assign push_msb = push & DIN[N-1];
  assign pop_msb  = pop & rd_data[N-1];

  fifo_sync_param_mem #(
    .N     (N),
    .WORDS (WORDS)
  ) u_mem (
    .clk     (CLK),
    .we      (push & ~RESET),
    .wr_addr (wr_ptr),
    .wr_data (DIN),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      msb_count <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);

      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (push_msb && !pop_msb)      msb_count <= msb_count + 1'b1;
      else if (pop_msb && !push_msb) msb_count <= msb_count - 1'b1;

      if (SI && !IREADY) ovf <= 1'b1;
      if (SO && !OREADY) unf <= 1'b1;
    end
  end

  // NOTE: default assignment first so the loop cannot leave any bit unassigned and infer a latch.
  always_comb begin
    FOUT = '0;
    for (int i = 0; i < WORDS; i++) begin
      FOUT[i] = (count > CW'(i));
    end
  end

  assign COUNT   = count;
  assign IREADY  = (count != CW'(WORDS));
  assign OREADY  = (count != '0);
  assign DOUT    = OREADY ? rd_data : '0;
  assign AFULL   = (count >= CW'(WORDS - AF_MARGIN));
  assign AEMPTY  = (count <= CW'(AE_MARGIN));
  assign DETECT1 = SLEEPER | (msb_count != '0);
  assign OVF     = ovf;
  assign UNF     = unf;

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 The block SHALL have parameter N, default 8, word width in bits (N >= 1).
REQ-002 The block SHALL have parameter WORDS, default 4, depth in words (WORDS >= 2, not restricted to a power of 2).
REQ-003 The block SHALL have parameter AF_MARGIN, default 1, almost-full margin (0 <= AF_MARGIN < WORDS).
REQ-004 The block SHALL have parameter AE_MARGIN, default 1, almost-empty margin (0 <= AE_MARGIN < WORDS).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset: CLK is the only clock, and RESET is synchronous and active-high.
REQ-006 The ports SHALL be, clock and reset first:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous active-high reset.
- DIN  in  N  write data.
- SI  in  1  shift-in (write) request.
- SO  in  1  shift-out (read) request.
- SLEEPER  in  1  forces DETECT1 high.
- DOUT  out  N  head-of-queue word.
- IREADY  out  1  space available.
- OREADY  out  1  data available.
- FOUT  out  WORDS  thermometer occupancy.
- COUNT  out  clog2(WORDS+1)  occupancy.
- AFULL  out  1  almost full.
- AEMPTY  out  1  almost empty.
- DETECT1  out  1  MSB-set word present.
- OVF  out  1  sticky overflow error.
- UNF  out  1  sticky underflow error.

Function
REQ-007 A push SHALL occur at a rising CLK edge when SI=1 and IREADY=1; DIN is written at the write pointer, which then advances.
REQ-008 A pop SHALL occur at a rising CLK edge when SO=1 and OREADY=1; the read pointer then advances.
REQ-009 Both pointers SHALL wrap from WORDS-1 to 0 for any WORDS.
REQ-010 IREADY SHALL equal (COUNT != WORDS) and OREADY SHALL equal (COUNT != 0); both are derived from registered state only, with no combinational path from SI or SO.
REQ-011 When the FIFO is full and SI=1, SO=1 in the same cycle, the pop SHALL occur, the push SHALL be rejected, and COUNT SHALL become WORDS-1.
REQ-012 When the FIFO is empty and SI=1, SO=1 in the same cycle, the push SHALL occur, no pop SHALL occur, and COUNT SHALL become 1.
REQ-013 When 0 < COUNT < WORDS and push and pop coincide, COUNT SHALL be unchanged and both pointers SHALL advance.
REQ-014 DOUT SHALL be first-word-fall-through: it equals the word at the read pointer whenever OREADY=1, and all-zero when OREADY=0.
REQ-015 The first pushed word SHALL appear on DOUT the cycle after the push, i.e. one-cycle write-to-read latency.
REQ-016 FOUT[i] SHALL be 1 if and only if COUNT > i; the vector fills from bit 0 upward.
REQ-017 AFULL SHALL equal (COUNT >= WORDS-AF_MARGIN) and AEMPTY SHALL equal (COUNT <= AE_MARGIN).
REQ-018 A counter SHALL track the number of stored words with bit N-1 set: it increments on a push of such a word, decrements on a pop of such a word, and is unchanged when both happen in one cycle.
REQ-019 DETECT1 SHALL equal SLEEPER OR (that counter != 0); DOUT's MSB is included because the head word is stored.
REQ-020 OVF SHALL set at the edge where SI=1 and IREADY=0, and hold until reset.
REQ-021 UNF SHALL set at the edge where SO=1 and OREADY=0, and hold until reset.
REQ-022 An X on SI or SO SHALL NOT be resolved in design; the bench flags it.

Reset
REQ-023 While RESET=1 at a rising CLK edge, the block SHALL clear both pointers, COUNT, the MSB counter, OVF and UNF.
REQ-024 After reset the outputs SHALL be: IREADY=1, OREADY=0, FOUT=0, COUNT=0, AFULL=0, AEMPTY=1, DOUT=0, DETECT1=SLEEPER.
REQ-025 Reset SHALL override simultaneous SI/SO; a push or pop in the reset cycle is discarded.
REQ-026 Storage contents SHALL NOT be reset.

Structure
REQ-027 Shared package fifo_pkg SHALL hold the clog2 function and the occupancy-width rule clog2(WORDS+1).
REQ-028 Storage SHALL be one sub-module, fifo_sync_param_mem: a WORDS x N register array with one write port and one asynchronous read port, with no reset.
REQ-029 Pointer, count and flag logic SHALL reside in fifo_sync_param.

Verification (N=8, WORDS=4, margins 1)
REQ-030 Scenario 1: reset, then push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> FOUT 0001, 0011, 0111, 1111; AFULL=1 at COUNT=3; IREADY=0 after the fourth push; DOUT=0x11.
REQ-031 Scenario 2: full, SI=SO=1 with DIN=0x55 -> 0x11 popped, 0x55 dropped, COUNT=3, OVF=1, DOUT=0x22.
REQ-032 Scenario 3: empty, SI=SO=1 with DIN=0x66 -> COUNT=1, UNF=1, DOUT=0x66 next cycle.
REQ-033 Scenario 4: push 0x80 then 0x01 -> DETECT1=1; pop once -> DETECT1=0; SLEEPER=1 while empty -> DETECT1=1.
REQ-034 Scenario 5: 10 interleaved push/pop pairs of 0x00..0x09 -> pointers wrap twice; output order is 0x00..0x09 with no loss.
REQ-035 Scenario 6: COUNT=3, RESET=1 for one cycle while SI=1 -> COUNT=0, OREADY=0, IREADY=1, FOUT=0000, OVF=UNF=0.
